// File: rtl/ulpi_reg_ctrl_if.sv
// Register-access request/response bundle between the link's register and
// config logic (master) and the ULPI bus controller (slave). The RX CMD
// forwarding outputs travel back on the same bundle.
interface ulpi_reg_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rx_cmd_valid;
  logic [7:0] rx_cmd;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rx_cmd_valid, rx_cmd
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rx_cmd_valid, rx_cmd
  );
endinterface

// File: rtl/ulpi_reg_ctrl.sv
// Link-side ULPI register-access controller.
//
// It arbitrates the 8-bit ULPI data bus between one register requester and
// the PHY. It sequences write and read TXCMDs, respects turnaround cycles,
// retries attempts the PHY aborts, and forwards RX CMD bytes.
//
// Build option: define ULPI_EXT_REG_EN to enable extended register
// addressing. With it, addresses >= 0x2F send TXCMD 0xAF/0xEF followed by
// the full address byte. Without it, only addr[5:0] is used.
module ulpi_reg_ctrl #(
  parameter int MAX_RETRY = 4
) (
  input  logic                  ulpi_clk,
  input  logic                  ulpi_reset_n,
  ulpi_reg_ctrl_if.slave        req_if,
  input  logic [7:0]            ulpi_data_in,
  output logic [7:0]            ulpi_data_out,
  output logic                  ulpi_data_oe,
  input  logic                  ulpi_dir,
  input  logic                  ulpi_nxt,
  output logic                  ulpi_stp
);

  localparam int RW = $clog2(MAX_RETRY + 1);

`ifdef ULPI_EXT_REG_EN
  localparam int AW = 8;
`else
  localparam int AW = 6;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
`ifdef ULPI_EXT_REG_EN
    S_EXT_ADDR,
`endif
    S_WR_DATA,
    S_WR_STP,
    S_RD_TURN,
    S_RD_DATA,
    S_WAIT_BUS
  } state_t;

  state_t          state_q, state_d, data_state;
  logic            dir_q;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      wdata_q;
  logic [RW-1:0]   retry_q, retry_d;
  logic            pend_q, pend_d;

  logic [7:0]      data_q, data_d;
  logic            stp_q;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rx_cmd_valid_q;
  logic [7:0]      rx_cmd_q;

  logic            accept;
  logic            bus_own;
  logic            dir_rise;
  logic            abort;
  logic            is_ext;
  logic            cur_write;
  logic [AW-1:0]   cur_addr;
  logic [7:0]      cur_wdata;

  assign accept    = req_if.req_valid & (state_q == S_IDLE);
  assign bus_own   = ~ulpi_dir & ~dir_q;
  assign dir_rise  = ulpi_dir & ~dir_q;

  // While a request is being accepted the latched copy is not loaded yet,
  // so the first TXCMD is built straight from the request inputs.
  assign cur_write = accept ? req_if.req_write : wr_q;
  assign cur_addr  = accept ? req_if.req_addr[AW-1:0] : addr_q;
  assign cur_wdata = accept ? req_if.req_wdata : wdata_q;

`ifdef ULPI_EXT_REG_EN
  assign is_ext    = (cur_addr >= 8'h2F);
`else
  assign is_ext    = 1'b0;
  // addr[7:6] carry no meaning in immediate-only builds.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, req_if.req_addr[7:6]};
`endif

  // The PHY may take the bus in CMD/EXT_ADDR before it takes the command,
  // or at any time during WR_DATA. Either case kills the attempt.
  always_comb begin
    abort = 1'b0;
    if (dir_rise) begin
      unique case (state_q)
        S_CMD:     abort = ~ulpi_nxt;
`ifdef ULPI_EXT_REG_EN
        S_EXT_ADDR: abort = ~ulpi_nxt;
`endif
        S_WR_DATA: abort = 1'b1;
        default:   abort = 1'b0;
      endcase
    end
  end

  assign data_state = cur_write ? S_WR_DATA : S_RD_TURN;

  // Next-state, retry bookkeeping and completion response.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. A path that
    // skips an assignment would otherwise infer a latch.
    state_d     = state_q;
    retry_d     = retry_q;
    pend_d      = pend_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    if (abort) begin
      state_d = S_WAIT_BUS;
      retry_d = retry_q + RW'(1);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_CMD;
            retry_d = '0;
            pend_d  = 1'b1;
          end
        end
        S_CMD: begin
          // A PHY already holding the bus (no rising edge) just stalls us.
          if (bus_own && ulpi_nxt) begin
`ifdef ULPI_EXT_REG_EN
            state_d = is_ext ? S_EXT_ADDR : data_state;
`else
            state_d = data_state;
`endif
          end
        end
`ifdef ULPI_EXT_REG_EN
        S_EXT_ADDR: begin
          if (bus_own && ulpi_nxt) state_d = data_state;
        end
`endif
        S_WR_DATA: begin
          if (bus_own && ulpi_nxt) state_d = S_WR_STP;
        end
        S_WR_STP: begin
          state_d     = S_IDLE;
          pend_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 8'h00;
        end
        S_RD_TURN: begin
          if (ulpi_dir) state_d = S_RD_DATA;
        end
        S_RD_DATA: begin
          state_d     = S_WAIT_BUS;
          pend_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ulpi_data_in;
        end
        S_WAIT_BUS: begin
          if (bus_own) begin
            if (!pend_q) begin
              state_d = S_IDLE;
            end else if (retry_q >= RW'(MAX_RETRY)) begin
              state_d     = S_IDLE;
              pend_d      = 1'b0;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = 8'h00;
            end else begin
              state_d = S_CMD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Link drive value for the cycle the next state will occupy.
  always_comb begin
    data_d = 8'h00;
    unique case (state_d)
      S_CMD:      data_d = {1'b1, ~cur_write, is_ext ? 6'h2F : cur_addr[5:0]};
`ifdef ULPI_EXT_REG_EN
      S_EXT_ADDR: data_d = cur_addr;
`endif
      S_WR_DATA:  data_d = cur_wdata;
      default:    data_d = 8'h00;
    endcase
  end

  // FSM state, bus direction history and latched request.
  always_ff @(posedge ulpi_clk or negedge ulpi_reset_n) begin
    if (!ulpi_reset_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      retry_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments, so every flop samples
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      dir_q   <= ulpi_dir;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      if (accept) begin
        wr_q    <= req_if.req_write;
        addr_q  <= req_if.req_addr[AW-1:0];
        wdata_q <= req_if.req_wdata;
      end
    end
  end

  // Registered pin drive, response and RX CMD outputs.
  always_ff @(posedge ulpi_clk or negedge ulpi_reset_n) begin
    if (!ulpi_reset_n) begin
      data_q         <= 8'h00;
      stp_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 8'h00;
      rsp_err_q      <= 1'b0;
      rx_cmd_valid_q <= 1'b0;
      rx_cmd_q       <= 8'h00;
    end else begin
      data_q         <= data_d;
      stp_q          <= (state_d == S_WR_STP);
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      // Bus held by PHY past turnaround, no nxt: a status byte, unless it
      // is the read data we are capturing.
      rx_cmd_valid_q <= ulpi_dir & dir_q & ~ulpi_nxt & (state_q != S_RD_DATA);
      if (ulpi_dir && dir_q && !ulpi_nxt && (state_q != S_RD_DATA)) begin
        rx_cmd_q <= ulpi_data_in;
      end
    end
  end

  assign ulpi_data_oe        = ~ulpi_dir & ~dir_q;
  assign ulpi_data_out       = data_q;
  assign ulpi_stp            = stp_q;
  assign req_if.req_ready    = (state_q == S_IDLE);
  assign req_if.rsp_valid    = rsp_valid_q;
  assign req_if.rsp_rdata    = rsp_rdata_q;
  assign req_if.rsp_err      = rsp_err_q;
  assign req_if.rx_cmd_valid = rx_cmd_valid_q;
  assign req_if.rx_cmd       = rx_cmd_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed self-checking bench for ulpi_reg_ctrl. Inputs change on the
// falling edge; outputs are sampled on the falling edge, half a cycle
// after the rising edge that updated them.
module tb_ulpi_reg_ctrl;

  logic       ulpi_clk = 1'b0;
  logic       ulpi_reset_n;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;

  int n_assert = 0;
  int n_fail   = 0;

  ulpi_reg_ctrl_if bus ();

  ulpi_reg_ctrl #(.MAX_RETRY(4)) dut (
    .ulpi_clk      (ulpi_clk),
    .ulpi_reset_n  (ulpi_reset_n),
    .req_if        (bus.slave),
    .ulpi_data_in  (ulpi_data_in),
    .ulpi_data_out (ulpi_data_out),
    .ulpi_data_oe  (ulpi_data_oe),
    .ulpi_dir      (ulpi_dir),
    .ulpi_nxt      (ulpi_nxt),
    .ulpi_stp      (ulpi_stp)
  );

  always #8 ulpi_clk = ~ulpi_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ulpi_clk);
  endtask

  // Write with the PHY taking every byte on its first cycle.
  task automatic write_txn(input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp_cmd, input bit ext);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    check("wr_txcmd", ulpi_data_out, exp_cmd);
    check("wr_busy", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    ulpi_nxt      = 1'b1;
    if (ext) begin
      tick();
      check("wr_ext_addr", ulpi_data_out, addr);
    end
    tick();
    check("wr_data", ulpi_data_out, wdata);
    check("wr_no_stp_yet", ulpi_stp, 1'b0);
    tick();
    check("wr_stp", ulpi_stp, 1'b1);
    check("wr_stp_noop", ulpi_data_out, 8'h00);
    check("wr_rsp_not_yet", bus.rsp_valid, 1'b0);
    ulpi_nxt = 1'b0;
    tick();
    check("wr_rsp_valid", bus.rsp_valid, 1'b1);
    check("wr_rsp_err", bus.rsp_err, 1'b0);
    check("wr_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("wr_stp_done", ulpi_stp, 1'b0);
    check("wr_ready", bus.req_ready, 1'b1);
    tick();
    check("wr_rsp_pulse", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    ulpi_reset_n  = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    ulpi_dir      = 1'b0;
    ulpi_nxt      = 1'b0;
    ulpi_data_in  = 8'h00;

    // Reset values.
    tick();
    tick();
    check("rst_data_out", ulpi_data_out, 8'h00);
    check("rst_stp", ulpi_stp, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rx_valid", bus.rx_cmd_valid, 1'b0);
    check("rst_rx_cmd", bus.rx_cmd, 8'h00);
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_oe", ulpi_data_oe, 1'b1);
    ulpi_reset_n = 1'b1;
    tick();

    // Write 0x0A <- 0x55.
    write_txn(8'h0A, 8'h55, 8'h8A, 1'b0);

    // Read 0x00, PHY returns 0x24 after turnaround.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    tick();
    check("rd_txcmd", ulpi_data_out, 8'hC0);
    bus.req_valid = 1'b0;
    ulpi_nxt      = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    ulpi_dir = 1'b1;
    #1 check("rd_oe_turn", ulpi_data_oe, 1'b0);
    tick();
    ulpi_data_in = 8'h24;
    #1 check("rd_oe_data", ulpi_data_oe, 1'b0);
    tick();
    check("rd_rsp_valid", bus.rsp_valid, 1'b1);
    check("rd_rsp_rdata", bus.rsp_rdata, 8'h24);
    check("rd_rsp_err", bus.rsp_err, 1'b0);
    check("rd_not_rxcmd", bus.rx_cmd_valid, 1'b0);
    ulpi_dir     = 1'b0;
    ulpi_data_in = 8'h00;
    #1 check("rd_oe_turn_back", ulpi_data_oe, 1'b0);
    tick();
    check("rd_rsp_pulse", bus.rsp_valid, 1'b0);
    check("rd_oe_restored", ulpi_data_oe, 1'b1);
    check("rd_wait_bus", bus.req_ready, 1'b0);
    tick();
    check("rd_ready", bus.req_ready, 1'b1);

    // Write 0x05 <- 0x33 aborted by RX CMD 0x4E before nxt, then retried.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h05;
    bus.req_wdata = 8'h33;
    tick();
    check("ab_txcmd", ulpi_data_out, 8'h85);
    bus.req_valid = 1'b0;
    ulpi_dir      = 1'b1;
    #1 check("ab_oe_dir", ulpi_data_oe, 1'b0);
    tick();
    ulpi_data_in = 8'h4E;
    tick();
    check("ab_rx_valid", bus.rx_cmd_valid, 1'b1);
    check("ab_rx_cmd", bus.rx_cmd, 8'h4E);
    check("ab_no_rsp", bus.rsp_valid, 1'b0);
    ulpi_nxt     = 1'b1;
    ulpi_data_in = 8'hAA;
    tick();
    check("ab_rx_pkt_ignored", bus.rx_cmd_valid, 1'b0);
    check("ab_rx_cmd_held", bus.rx_cmd, 8'h4E);
    ulpi_dir     = 1'b0;
    ulpi_nxt     = 1'b0;
    ulpi_data_in = 8'h00;
    tick();
    check("ab_no_rsp_turn", bus.rsp_valid, 1'b0);
    tick();
    check("ab_retry_txcmd", ulpi_data_out, 8'h85);
    check("ab_retry_busy", bus.req_ready, 1'b0);
    ulpi_nxt = 1'b1;
    tick();
    check("ab_retry_data", ulpi_data_out, 8'h33);
    tick();
    check("ab_retry_stp", ulpi_stp, 1'b1);
    ulpi_nxt = 1'b0;
    tick();
    check("ab_rsp_valid", bus.rsp_valid, 1'b1);
    check("ab_rsp_err", bus.rsp_err, 1'b0);
    tick();
    check("ab_single_rsp", bus.rsp_valid, 1'b0);

    // Four consecutive aborts of write 0x07 exhaust the retries.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h07;
    bus.req_wdata = 8'h01;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rt_txcmd", ulpi_data_out, 8'h87);
      check("rt_no_rsp", bus.rsp_valid, 1'b0);
      ulpi_dir = 1'b1;
      tick();
      ulpi_dir = 1'b0;
      tick();
      tick();
    end
    check("rt_rsp_valid", bus.rsp_valid, 1'b1);
    check("rt_rsp_err", bus.rsp_err, 1'b1);
    check("rt_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("rt_ready", bus.req_ready, 1'b1);
    check("rt_noop", ulpi_data_out, 8'h00);
    tick();
    check("rt_rsp_pulse", bus.rsp_valid, 1'b0);

    // Reset asserted during WR_DATA.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h12;
    bus.req_wdata = 8'h9C;
    tick();
    bus.req_valid = 1'b0;
    ulpi_nxt      = 1'b1;
    tick();
    check("rs_in_wr_data", ulpi_data_out, 8'h9C);
    ulpi_nxt     = 1'b0;
    ulpi_reset_n = 1'b0;
    #1;
    check("rs_stp", ulpi_stp, 1'b0);
    check("rs_data_out", ulpi_data_out, 8'h00);
    check("rs_idle", bus.req_ready, 1'b1);
    check("rs_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    ulpi_reset_n = 1'b1;
    tick();
    check("rs_after_no_rsp", bus.rsp_valid, 1'b0);
    check("rs_after_stp", ulpi_stp, 1'b0);
    check("rs_after_idle", bus.req_ready, 1'b1);
    tick();

`ifdef ULPI_EXT_REG_EN
    // Extended write, then the last immediate address below the threshold.
    write_txn(8'h80, 8'h11, 8'hAF, 1'b1);
    write_txn(8'h2E, 8'h01, 8'hAE, 1'b0);
`else
    // Upper address bits are dropped: 0xCA encodes like 0x0A.
    write_txn(8'hCA, 8'hA5, 8'h8A, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
